// File: rtl/px_route_arbiter_pkg.sv
// Shared types and constants for the SPI pixel-channel arbiter.
// The FSM state encoding lives here so the top and any observers agree on it.
package px_route_arbiter_pkg;

    localparam int MAX_PIXEL_BITS   = 24;
    localparam int DEF_DRAIN_CYCLES = 32;

    typedef enum logic [1:0] {S_GS, S_LFSR, S_DRAIN, S_SWITCH} arb_state_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == S_DRAIN) || (s == S_SWITCH);
    endfunction

    function automatic arb_state_t run_state(input logic lfsr_mode);
        return lfsr_mode ? S_LFSR : S_GS;
    endfunction

endpackage

// File: rtl/px_route_arbiter_if.sv
// Bundle of SPI, GS and LFSR handshake signals around the pixel-channel arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface px_route_arbiter_if
    import px_route_arbiter_pkg::*;
    ();

    logic                      mode_lfsr_i;
    logic                      spi_px_rdy_i;
    logic [MAX_PIXEL_BITS-1:0] spi_px_i;
    logic                      spi_px_rdy_o;
    logic [MAX_PIXEL_BITS-1:0] spi_px_o;
    logic                      gs_px_rdy_o;
    logic [MAX_PIXEL_BITS-1:0] gs_px_o;
    logic                      gs_px_rdy_i;
    logic [MAX_PIXEL_BITS-1:0] gs_px_i;
    logic                      lfsr_rdy_o;
    logic [MAX_PIXEL_BITS-1:0] lfsr_data_o;
    logic                      lfsr_done_i;
    logic [MAX_PIXEL_BITS-1:0] lfsr_data_i;
    logic                      mode_lfsr_o;
    logic                      busy_o;
    logic                      overflow_o;
    logic                      ovf_clr_i;

    modport master (
        input  mode_lfsr_i, spi_px_rdy_i, spi_px_i, gs_px_rdy_i, gs_px_i,
               lfsr_done_i, lfsr_data_i, ovf_clr_i,
        output spi_px_rdy_o, spi_px_o, gs_px_rdy_o, gs_px_o, lfsr_rdy_o,
               lfsr_data_o, mode_lfsr_o, busy_o, overflow_o
    );

    modport slave (
        output mode_lfsr_i, spi_px_rdy_i, spi_px_i, gs_px_rdy_i, gs_px_i,
               lfsr_done_i, lfsr_data_i, ovf_clr_i,
        input  spi_px_rdy_o, spi_px_o, gs_px_rdy_o, gs_px_o, lfsr_rdy_o,
               lfsr_data_o, mode_lfsr_o, busy_o, overflow_o
    );

endinterface

// File: rtl/px_arb_drain_timer.sv
// Counts consecutive quiet cycles on the consumer being drained.
// Held at zero outside the drain window; saturates at DRAIN_CYCLES-1.
module px_arb_drain_timer #(
    parameter int DRAIN_CYCLES = 32
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic restart,
    input  logic activity,
    output logic expired
);

    localparam int CW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            count_reg <= '0;
        end else if (restart || activity) begin
            count_reg <= '0;
        end else if (count_reg != LAST) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/px_route_arbiter.sv
// Routes SPI pixel words to either the GS pipeline or the LFSR config port and
// returns results; a mode change waits for the old consumer to go quiet first.
module px_route_arbiter
    import px_route_arbiter_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    px_route_arbiter_if.master bus
);

    localparam int W = MAX_PIXEL_BITS;

    arb_state_t     state_reg, state_next;
    logic           mode_reg, mode_next;
    logic           hold_valid_reg, hold_valid_next;
    logic [W-1:0]   hold_data_reg, hold_data_next;
    logic           disp_valid, disp_lfsr, ovf_set;
    logic [W-1:0]   disp_data;
    logic           ret_valid, drain_expired;
    logic [W-1:0]   ret_data;

    logic           spi_rdy_reg, gs_rdy_reg, lfsr_rdy_reg, ovf_reg;
    logic [W-1:0]   spi_px_reg, gs_px_reg, lfsr_data_reg;

    // Results follow the applied mode, so the old consumer still returns while draining.
    assign ret_valid = mode_reg ? bus.lfsr_done_i : bus.gs_px_rdy_i;
    assign ret_data  = mode_reg ? bus.lfsr_data_i : bus.gs_px_i;

    px_arb_drain_timer #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_drain_timer (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .restart  (state_reg != S_DRAIN),
        .activity (ret_valid),
        .expired  (drain_expired)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_reg <= S_GS;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        disp_valid      = 1'b0;
        disp_data       = hold_data_reg;
        disp_lfsr       = mode_reg;
        ovf_set         = 1'b0;

        if (state_reg == S_DRAIN) begin
            if (bus.spi_px_rdy_i) begin
                if (hold_valid_reg) begin
                    ovf_set = 1'b1;
                end else begin
                    hold_valid_next = 1'b1;
                    hold_data_next  = bus.spi_px_i;
                end
            end
        end else begin
            // Held word wins; a fresh word in the same cycle takes its place in hold.
            if (hold_valid_reg) begin
                disp_valid = 1'b1;
                if (bus.spi_px_rdy_i) hold_data_next  = bus.spi_px_i;
                else                  hold_valid_next = 1'b0;
            end else if (bus.spi_px_rdy_i) begin
                disp_valid = 1'b1;
                disp_data  = bus.spi_px_i;
            end
        end

        case (state_reg)
            S_GS, S_LFSR: begin
                if (bus.mode_lfsr_i != mode_reg) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.mode_lfsr_i == mode_reg) state_next = run_state(mode_reg);
                else if (drain_expired)          state_next = S_SWITCH;
            end
            S_SWITCH: begin
                mode_next  = ~mode_reg;
                disp_lfsr  = ~mode_reg;
                state_next = run_state(~mode_reg);
            end
            default: state_next = S_GS;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            mode_reg       <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            spi_rdy_reg    <= 1'b0;
            spi_px_reg     <= '0;
            gs_rdy_reg     <= 1'b0;
            gs_px_reg      <= '0;
            lfsr_rdy_reg   <= 1'b0;
            lfsr_data_reg  <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            mode_reg       <= mode_next;
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
            spi_rdy_reg    <= ret_valid;
            if (ret_valid) spi_px_reg <= ret_data;
            gs_rdy_reg     <= disp_valid && !disp_lfsr;
            if (disp_valid && !disp_lfsr) gs_px_reg <= disp_data;
            lfsr_rdy_reg   <= disp_valid && disp_lfsr;
            if (disp_valid && disp_lfsr) lfsr_data_reg <= disp_data;
            if (ovf_set)            ovf_reg <= 1'b1;
            else if (bus.ovf_clr_i) ovf_reg <= 1'b0;
        end
    end

    assign bus.spi_px_rdy_o = spi_rdy_reg;
    assign bus.spi_px_o     = spi_px_reg;
    assign bus.gs_px_rdy_o  = gs_rdy_reg;
    assign bus.gs_px_o      = gs_px_reg;
    assign bus.lfsr_rdy_o   = lfsr_rdy_reg;
    assign bus.lfsr_data_o  = lfsr_data_reg;
    assign bus.mode_lfsr_o  = mode_reg;
    assign bus.busy_o       = is_busy(state_reg);
    assign bus.overflow_o   = ovf_reg;

endmodule
